// File: rtl/spike_pkg.sv
// Shared spike-train constants and types, common to the decoder and lif-side blocks.
package spike_pkg;

  localparam int WIN_BASE  = 16;
  localparam int WIN_SEL_W = 3;
  localparam int WIN_CNT_W = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // Index of the terminal cycle of a window of (WIN_BASE << sel) cycles.
  function automatic logic [WIN_CNT_W-1:0] win_last(input logic [WIN_SEL_W-1:0] sel);
    logic [WIN_CNT_W:0] len;
    len = (WIN_CNT_W+1)'(WIN_BASE) << sel;
    len = len - (WIN_CNT_W+1)'(1);
    return len[WIN_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/spike_isi_timer.sv
// Rising-edge detector plus saturating inter-spike-interval counter.
// All history is cleared whenever run_i is low.
module spike_isi_timer #(
  parameter int ISI_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             spike_i,
  output logic             edge_o,
  output logic [ISI_W-1:0] isi_o
);

  logic             prev_q;
  logic             seen_q;
  logic [ISI_W-1:0] cnt_q;
  logic [ISI_W-1:0] last_q;

  assign edge_o = run_i && spike_i && !prev_q;
  // Includes an interval completing this cycle so a window-end latch sees it.
  assign isi_o  = (edge_o && seen_q) ? cnt_q : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
      last_q <= '0;
    end else if (!run_i) begin
      prev_q <= 1'b0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      prev_q <= spike_i;
      if (edge_o) begin
        seen_q <= 1'b1;
        last_q <= isi_o;
        cnt_q  <= ISI_W'(1);
      end else if (cnt_q != '1) begin
        cnt_q  <= cnt_q + ISI_W'(1);
      end
    end
  end

endmodule

// File: rtl/spike_decoder.sv
// Windowed rate and ISI decoder for a lif spike train, with a valid/ready
// result register and a sticky overrun flag.
module spike_decoder
  import spike_pkg::*;
#(
  parameter int RATE_W = 8,
  parameter int ISI_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 spike_in,
  input  logic [WIN_SEL_W-1:0] win_sel,
  output logic [RATE_W-1:0]    rate_out,
  output logic [ISI_W-1:0]     isi_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun
);

  state_e                 state_q;
  logic [WIN_SEL_W-1:0]   sel_q;
  logic [WIN_CNT_W-1:0]   win_cnt_q;
  logic [RATE_W-1:0]      rate_cnt_q;
  logic [RATE_W-1:0]      rate_d;
  logic [RATE_W-1:0]      rate_q;
  logic [ISI_W-1:0]       isi_q;
  logic                   valid_q;
  logic                   overrun_q;
  logic                   run;
  logic                   win_end;
  logic                   spk_edge;
  logic [ISI_W-1:0]       isi_now;

  assign run     = (state_q == COUNT) && ena;
  assign win_end = run && (win_cnt_q == win_last(sel_q));
  assign rate_d  = (spk_edge && rate_cnt_q != '1) ? rate_cnt_q + RATE_W'(1) : rate_cnt_q;

  spike_isi_timer #(.ISI_W(ISI_W)) u_isi (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .run_i   (run),
    .spike_i (spike_in),
    .edge_o  (spk_edge),
    .isi_o   (isi_now)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      win_cnt_q  <= '0;
      rate_cnt_q <= '0;
      rate_q     <= '0;
      isi_q      <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ena) begin
          state_q <= COUNT;
          sel_q   <= win_sel;
        end
        COUNT: begin
          if (!ena)        state_q <= IDLE;
          else if (win_end) sel_q  <= win_sel;
        end
        default: state_q <= IDLE;
      endcase

      // Dropping ena discards the partial window; a window end restarts with no gap.
      if (!run || win_end) begin
        win_cnt_q  <= '0;
        rate_cnt_q <= '0;
      end else begin
        win_cnt_q  <= win_cnt_q + WIN_CNT_W'(1);
        rate_cnt_q <= rate_d;
      end

      if (win_end) begin
        rate_q  <= rate_d;
        isi_q   <= isi_now;
        valid_q <= 1'b1;
        if (valid_q && !ready) overrun_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rate_out = rate_q;
  assign isi_out  = isi_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spike_decoder.sv
// Directed scoreboard bench for spike_decoder: stimulus queues expected results,
// a monitor branch checks each one as it is handed off.
module tb_spike_decoder;

  localparam int RW = 8;
  localparam int IW = 8;

  typedef struct packed {
    logic [RW-1:0] rate;
    logic [IW-1:0] isi;
    logic          ovr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          spike_in;
  logic [2:0]    win_sel;
  logic [RW-1:0] rate_out;
  logic [IW-1:0] isi_out;
  logic          valid;
  logic          ready;
  logic          overrun;

  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  spike_decoder #(.RATE_W(RW), .ISI_W(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .spike_in (spike_in),
    .win_sel  (win_sel),
    .rate_out (rate_out),
    .isi_out  (isi_out),
    .valid    (valid),
    .ready    (ready),
    .overrun  (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_res(input int r, input int i, input int o);
    exp_t e;
    e.rate = RW'(r);
    e.isi  = IW'(i);
    e.ovr  = o[0];
    exp_q.push_back(e);
  endtask

  task automatic enter(input logic [2:0] sel);
    win_sel = sel;
    ena     = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; ready = 1'b0; win_sel = 3'd0;
    fork
      begin : stim
        step(); step();
        chk("reset rate_out", int'(rate_out), 0);
        chk("reset isi_out", int'(isi_out), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset overrun", int'(overrun), 0);
        rst_n = 1'b1;
        step();

        // basic: pulses every 4 cycles from window cycle 0
        ready = 1'b1;
        expect_res(4, 4, 0);
        enter(3'd0);
        for (int k = 0; k < 16; k++) begin spike_in = (k % 4 == 0); step(); end
        chk("basic valid at cycle 16", int'(valid), 1);
        spike_in = 1'b0; ena = 1'b0; step();
        chk("basic valid after handshake", int'(valid), 0);

        // held level counts once, no interval
        expect_res(1, 0, 0);
        enter(3'd0);
        for (int k = 0; k < 16; k++) begin spike_in = 1'b1; step(); end
        chk("held valid", int'(valid), 1);
        spike_in = 1'b0; ena = 1'b0; step();

        // saturation; mid-window win_sel changes must be ignored
        expect_res(255, 2, 0);
        expect_res(2, 255, 0);
        enter(3'd7);
        for (int k = 0; k < 2048; k++) begin
          spike_in = (k % 2 == 0);
          if (k == 100)  win_sel = 3'd0;
          if (k == 2000) win_sel = 3'd7;
          step();
        end
        chk("sat window1 valid", int'(valid), 1);
        for (int k = 0; k < 2048; k++) begin spike_in = (k == 0 || k == 300); step(); end
        chk("sat window2 valid", int'(valid), 1);
        spike_in = 1'b0; ena = 1'b0; step();

        // handshake coinciding with a new result
        ready = 1'b0;
        enter(3'd0);
        for (int k = 0; k < 16; k++) begin spike_in = (k == 3); step(); end
        expect_res(1, 0, 0);
        expect_res(2, 8, 0);
        for (int k = 0; k < 16; k++) begin
          spike_in = (k == 0 || k == 8);
          ready    = (k == 15);
          step();
        end
        chk("simul valid", int'(valid), 1);
        chk("simul overrun", int'(overrun), 0);
        chk("simul rate_out", int'(rate_out), 2);
        spike_in = 1'b0; ena = 1'b0; step();
        chk("simul valid cleared", int'(valid), 0);

        // overrun: two windows unconsumed
        ready = 1'b0;
        enter(3'd0);
        for (int k = 0; k < 16; k++) begin spike_in = (k == 0 || k == 4); step(); end
        for (int k = 0; k < 16; k++) begin spike_in = (k == 0 || k == 5 || k == 10); step(); end
        chk("overrun valid", int'(valid), 1);
        chk("overrun flag set", int'(overrun), 1);
        expect_res(3, 5, 1);
        ready = 1'b1; ena = 1'b0; spike_in = 1'b0; step();
        chk("overrun valid cleared", int'(valid), 0);
        chk("overrun sticky", int'(overrun), 1);

        // ena dropped mid-window: partial discarded
        enter(3'd0);
        for (int k = 0; k < 8; k++) begin spike_in = (k == 1 || k == 5); step(); end
        ena = 1'b0; spike_in = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("ena-drop no result", int'(valid), 0);
        expect_res(1, 0, 1);
        enter(3'd0);
        for (int k = 0; k < 16; k++) begin spike_in = (k == 6); step(); end
        chk("ena-drop next window valid", int'(valid), 1);
        ena = 1'b0; step();

        // async reset mid-window; spike already high at first COUNT cycle
        enter(3'd0);
        for (int k = 0; k < 8; k++) begin spike_in = (k == 1 || k == 5); step(); end
        rst_n = 1'b0; ena = 1'b0; spike_in = 1'b1;
        #1;
        chk("async reset rate_out", int'(rate_out), 0);
        chk("async reset overrun", int'(overrun), 0);
        chk("async reset valid", int'(valid), 0);
        step(); step(); step();
        rst_n = 1'b1;
        step();
        chk("post-reset no result", int'(valid), 0);
        expect_res(1, 0, 0);
        enter(3'd0);
        for (int k = 0; k < 16; k++) begin spike_in = (k < 2); step(); end
        chk("post-reset window valid", int'(valid), 1);
        ena = 1'b0; spike_in = 1'b0; step();
        step();
        done = 1'b1;
      end
      begin : monitor
        exp_t e;
        while (!done) begin
          @(negedge clk);
          if (rst_n && valid && ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL result: unexpected rate=%0d isi=%0d ovr=%0b", rate_out, isi_out, overrun);
            end else begin
              e = exp_q.pop_front();
              if (rate_out !== e.rate || isi_out !== e.isi || overrun !== e.ovr) begin
                n_err++;
                $display("FAIL result: got rate=%0d isi=%0d ovr=%0b, expected rate=%0d isi=%0d ovr=%0b",
                         rate_out, isi_out, overrun, e.rate, e.isi, e.ovr);
              end
            end
          end
        end
      end
    join
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
